// File: rtl/ysyx_22050243_ibus_bridge.sv
// Instruction-fetch bridge: core fetch requests to a single-outstanding
// AXI-like read bus, with a one-entry instruction buffer and timeout.
module ysyx_22050243_ibus_bridge #(
   parameter int ADDR_WIDTH     = 64,
   parameter int BUS_DATA_WIDTH = 64,
   parameter int INST_WIDTH     = 32,
   parameter int TIMEOUT        = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      inst_addr_valid,
   input  logic [ADDR_WIDTH-1:0]     inst_addr,
   input  logic                      flush,
   output logic [INST_WIDTH-1:0]     inst_o,
   output logic                      inst_valid_o,
   output logic                      fetch_err_o,
   output logic                      busy_o,
   output logic                      ar_valid_o,
   input  logic                      ar_ready,
   output logic [ADDR_WIDTH-1:0]     ar_addr_o,
   input  logic                      r_valid,
   output logic                      r_ready_o,
   input  logic [BUS_DATA_WIDTH-1:0] r_data,
   input  logic [1:0]                r_resp
);

   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_DROP
   } state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic [ADDR_WIDTH-1:0]   r_req_addr;
   logic                    r_drop;
   logic                    r_last_valid;
   logic [ADDR_WIDTH-1:0]   r_last_addr;
   logic [INST_WIDTH-1:0]   r_last_inst;
   logic [INST_WIDTH-1:0]   r_inst;
   logic                    r_inst_valid;
   logic                    r_err;
   logic [CNT_W-1:0]        r_cnt;

   logic                    w_start;
   logic                    w_hit;
   logic                    w_misal;
   logic                    w_ok;
   logic                    w_rerr;
   logic                    w_tout;
   logic                    w_cnt_clr;
   logic                    w_cnt_inc;
   logic                    w_deliver;
   logic [INST_WIDTH-1:0]   w_lane;

   assign w_lane = r_req_addr[2] ? r_data[INST_WIDTH +: INST_WIDTH]
                                 : r_data[0 +: INST_WIDTH];

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_start    = 1'b0;
      w_hit      = 1'b0;
      w_misal    = 1'b0;
      w_ok       = 1'b0;
      w_rerr     = 1'b0;
      w_tout     = 1'b0;
      w_cnt_clr  = 1'b0;
      w_cnt_inc  = 1'b0;
      ar_valid_o = 1'b0;
      ar_addr_o  = '0;
      r_ready_o  = 1'b0;
      busy_o     = 1'b1;
      unique case (r_state)
         S_IDLE: begin
            busy_o = 1'b0;
            if (inst_addr_valid && !flush) begin
               if (inst_addr[1:0] != 2'b00) begin
                  w_misal = 1'b1;
               end else if (r_last_valid && inst_addr == r_last_addr) begin
                  w_hit = 1'b1;
               end else begin
                  w_start = 1'b1;
                  w_next  = S_ADDR;
               end
            end
         end
         S_ADDR: begin
            ar_valid_o = 1'b1;
            ar_addr_o  = {r_req_addr[ADDR_WIDTH-1:3], 3'b000};
            if (ar_ready) begin
               w_cnt_clr = 1'b1;
               w_next    = (r_drop || flush) ? S_DROP : S_DATA;
            end
         end
         S_DATA: begin
            r_ready_o = 1'b1;
            if (flush) begin
               w_next = r_valid ? S_IDLE : S_DROP;
            end else if (r_valid) begin
               w_next = S_IDLE;
               if (r_resp == 2'b00) w_ok = 1'b1;
               else                 w_rerr = 1'b1;
            end else if (r_cnt == CNT_LAST) begin
               // TIMEOUT data cycles have now elapsed with no response
               w_tout = 1'b1;
               w_next = S_DROP;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         S_DROP: begin
            r_ready_o = 1'b1;
            if (r_valid) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_deliver = w_ok && inst_addr_valid && (inst_addr == r_req_addr);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_req_addr   <= '0;
         r_drop       <= 1'b0;
         r_last_valid <= 1'b0;
         r_last_addr  <= '0;
         r_last_inst  <= '0;
         r_inst       <= '0;
         r_inst_valid <= 1'b0;
         r_err        <= 1'b0;
         r_cnt        <= '0;
      end else begin
         r_inst_valid <= w_hit || w_deliver;
         r_err        <= w_misal || w_rerr || w_tout;
         if (w_start) r_req_addr <= inst_addr;
         if (w_start)                        r_drop <= 1'b0;
         else if (r_state == S_ADDR && flush) r_drop <= 1'b1;
         if (w_hit)          r_inst <= r_last_inst;
         else if (w_deliver) r_inst <= w_lane;
         if (w_ok) begin
            r_last_inst  <= w_lane;
            r_last_addr  <= r_req_addr;
            r_last_valid <= 1'b1;
         end
         if (flush || w_rerr) r_last_valid <= 1'b0;
         if (w_cnt_clr)      r_cnt <= '0;
         else if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign inst_o       = r_inst;
   assign inst_valid_o = r_inst_valid;
   assign fetch_err_o  = r_err;

endmodule

// File: doc/ysyx_22050243_ibus_bridge.md
YSYX_22050243_IBUS_BRIDGE -- requirements
Module: ysyx_22050243_ibus_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, giving the fetch and bus address width.
REQ-002 SHALL have parameter BUS_DATA_WIDTH, default 64, giving the read-data bus width.
REQ-003 SHALL have parameter INST_WIDTH, default 32, giving the instruction width.
REQ-004 SHALL have parameter TIMEOUT, default 255, giving the maximum number of DATA-state cycles before error.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  input  1  clock; rst  input  1  synchronous active-high reset.
REQ-006 SHALL have inst_addr_valid  input  1  core fetch request.
REQ-007 SHALL have inst_addr  input  ADDR_WIDTH  core fetch PC.
REQ-008 SHALL have flush  input  1  pipeline flush that drops in-flight fetches and invalidates the buffer.
REQ-009 SHALL have inst_o  output  INST_WIDTH  fetched instruction.
REQ-010 SHALL have inst_valid_o  output  1  one-cycle pulse marking inst_o valid.
REQ-011 SHALL have fetch_err_o  output  1  one-cycle error pulse.
REQ-012 SHALL have busy_o  output  1  high while the state is not IDLE.
REQ-013 SHALL have the read-address channel: ar_valid_o  output  1; ar_ready  input  1; ar_addr_o  output  ADDR_WIDTH.
REQ-014 SHALL have the read-data channel: r_valid  input  1; r_ready_o  output  1; r_data  input  BUS_DATA_WIDTH; r_resp  input  2.

Function
REQ-015 SHALL implement the FSM states IDLE, ADDR, DATA and DROP.
REQ-016 SHALL keep a one-entry buffer holding last_valid, last_addr and last_inst.
REQ-017 In IDLE with inst_addr_valid=1, flush=0 and inst_addr[1:0]!=0, SHALL pulse fetch_err_o the next cycle and stay in IDLE.
REQ-018 In IDLE with inst_addr_valid=1, flush=0, last_valid=1 and inst_addr==last_addr, SHALL set inst_o=last_inst and pulse inst_valid_o the next cycle, with no bus transaction.
REQ-019 Otherwise, in IDLE with an aligned request, SHALL latch req_addr<=inst_addr and enter ADDR.
REQ-020 In ADDR, SHALL hold ar_valid_o=1 and ar_addr_o={req_addr[ADDR_WIDTH-1:3],3'b000} stable until ar_ready=1, then enter DATA.
REQ-021 In DATA, SHALL hold r_ready_o=1; the bridge has at most one outstanding transaction.
REQ-022 On r_valid=1 with r_resp==0, SHALL select lane r_data[63:32] if req_addr[2]=1, else r_data[31:0].
REQ-023 On that response, SHALL write the selected lane into last_inst, write last_addr=req_addr, set last_valid=1, and enter IDLE.
REQ-024 On that response, SHALL drive inst_o and pulse inst_valid_o the next cycle only if inst_addr_valid=1 and inst_addr==req_addr; otherwise it only updates the buffer.
REQ-025 On r_valid=1 with r_resp!=0, SHALL pulse fetch_err_o, clear last_valid, and enter IDLE.
REQ-026 SHALL count DATA-state cycles in an 8-bit-or-wider counter, cleared on entry to DATA.
REQ-027 When the DATA-state count reaches TIMEOUT without r_valid, SHALL pulse fetch_err_o and enter DROP.
REQ-028 On flush in any state, SHALL clear last_valid and suppress any inst_valid_o pulse for that cycle's response.
REQ-029 On flush in IDLE, SHALL start no new request that cycle.
REQ-030 On flush in ADDR, SHALL keep ar_valid_o asserted until ar_ready=1, then enter DROP.
REQ-031 On flush in DATA, SHALL enter DROP; if r_valid=1 in the same cycle, SHALL discard the data and enter IDLE.
REQ-032 In DROP, SHALL hold r_ready_o=1, discard the response on r_valid=1 without any pulse, and enter IDLE.
REQ-033 SHALL hold inst_o at its last value between pulses.
REQ-034 SHALL never assert inst_valid_o and fetch_err_o in the same cycle.
REQ-035 SHALL drive busy_o=1 in ADDR, DATA and DROP, and 0 in IDLE.

Reset
REQ-036 On rst=1 at a clk edge, SHALL set state=IDLE, last_valid=0 and counter=0, and drive inst_o, inst_valid_o, fetch_err_o, ar_valid_o, r_ready_o, busy_o and ar_addr_o to 0.
REQ-037 A rst asserted mid-transaction SHALL abandon the transaction, and a late r_valid after reset SHALL be ignored while in IDLE.
REQ-038 rst SHALL take priority over flush and all bus inputs.

Verification
REQ-039 Bench SHALL cover: inst_addr=0x8000_0004 with ar_ready after 2 cycles and r_data=0x0010_0093_0000_0013, resp 0 -> ar_addr_o=0x8000_0000, inst_o=0x0010_0093, single inst_valid_o pulse.
REQ-040 Bench SHALL cover: re-request of 0x8000_0004 right after that fetch -> inst_valid_o the next cycle, ar_valid_o stays 0.
REQ-041 Bench SHALL cover: inst_addr=0x8000_0002 -> fetch_err_o pulse, no ar_valid_o.
REQ-042 Bench SHALL cover: flush during DATA, then r_valid -> no inst_valid_o, state IDLE, and a re-request of the same address issues a new ar_valid_o.
REQ-043 Bench SHALL cover: r_resp=2'b10 -> fetch_err_o pulse, last_valid=0; and no r_valid for 255 cycles -> fetch_err_o pulse, busy_o stays 1 until r_valid.
REQ-044 Bench SHALL cover: rst asserted in ADDR -> all outputs 0 the next cycle.
